dmem_dma: RTL

Word-copy DMA engine that acts as bus initiator on the data-memory/MMIO bus. The bus uses address `a`, write enable `we`, write data `wd`, combinational read data `rd`, and a synchronous write. It copies `len` 32-bit words from a source address range to a destination address range, one word at a time. The CPU is the other initiator; the top-level arbiter grants the bus via a req/gnt handshake, and the arbiter muxes `a`/`we`/`wd` into the data memory.

---
 rtl/dma_pkg.sv | 25 ++
 rtl/dmem_dma_if.sv | 12 +
 rtl/dmem_dma.sv | 103 ++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and bus map for the data-memory word-copy DMA.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [31:0] DMEM_BASE = 32'h0000_1000;
  localparam logic [31:0] DMEM_END  = 32'h0000_1040;
  localparam logic [31:0] PORTA     = 32'h0000_7f00;
  localparam logic [31:0] PORTB     = 32'h0000_7f10;
  localparam logic [31:0] PORTC     = 32'h0000_7f20;
  localparam logic [31:0] PORTD     = 32'h0000_7ffc;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_dma_if.sv
// Data-memory bus as seen by one initiator: request/grant plus a/we/wd/rd.
interface dmem_dma_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output bus_req, a, we, wd, input bus_gnt, rd);
  modport slave  (input bus_req, a, we, wd, output bus_gnt, rd);
endinterface

// File: rtl/dmem_dma.sv
// Word-copy DMA: reads one source word, writes it to the destination, repeats
// until the count is exhausted; every bus access waits for the arbiter grant.
module dmem_dma
  import dma_pkg::*;
#(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  dmem_dma_if.master       bus
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_data;
  logic [LEN_W-1:0] r_cnt;
  logic             r_err;
  logic             w_aligned;
  logic             w_accept;

  assign w_aligned = word_aligned(src_addr[1:0]) && word_aligned(dst_addr[1:0]);
  assign w_accept  = (r_state == IDLE) && start && w_aligned;
  assign err       = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // we follows the grant combinationally so an ungranted cycle never writes
  always_comb begin
    w_next      = r_state;
    bus.bus_req = 1'b0;
    bus.a       = '0;
    bus.we      = 1'b0;
    bus.wd      = '0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = (len == '0) ? DONE : REQ;
      end
      REQ: begin
        busy        = 1'b1;
        bus.bus_req = 1'b1;
        if (bus.bus_gnt) w_next = READ;
      end
      READ: begin
        busy        = 1'b1;
        bus.bus_req = 1'b1;
        bus.a       = r_src;
        if (bus.bus_gnt) w_next = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        bus.bus_req = 1'b1;
        bus.a       = r_dst;
        bus.wd      = r_data;
        bus.we      = bus.bus_gnt;
        if (bus.bus_gnt) w_next = (r_cnt == LEN_W'(1)) ? DONE : READ;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_data <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && start && !w_aligned;
      if (w_accept && (len != '0)) begin
        r_src <= src_addr;
        r_dst <= dst_addr;
        r_cnt <= len;
      end
      if ((r_state == READ) && bus.bus_gnt) r_data <= bus.rd;
      // address wrap past 0xFFFFFFFC is plain modulo arithmetic
      if ((r_state == WRITE) && bus.bus_gnt) begin
        r_src <= r_src + WORD_BYTES;
        r_dst <= r_dst + WORD_BYTES;
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

endmodule
